// File: rtl/dvbs2_pl_pkg.sv
// Shared state type and default framing constants for the DVB-S2 PL sequencer.
package dvbs2_pl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StPilot,
    StDummy
  } pl_state_e;

  localparam int unsigned DefDw          = 16;
  localparam int unsigned DefHdrLen      = 90;
  localparam int unsigned DefSlotLen     = 90;
  localparam int unsigned DefPilotLen    = 36;
  localparam int unsigned DefPilotPeriod = 16;
  localparam int unsigned DefMaxSlots    = 360;
  localparam int unsigned DefDummySlots  = 36;

  localparam logic signed [15:0] DefDummyVal = 16'sh0b50;

  localparam int unsigned SymCntW  = 7;
  localparam int unsigned SlotCntW = 9;
  localparam int unsigned BlkCntW  = 4;

endpackage

// File: rtl/pl_seg_counter.sv
// Symbol/slot/pilot-block counters for the PL framer; flags segment end, frame end
// and the slot boundaries that must be followed by a pilot block.
module pl_seg_counter
  import dvbs2_pl_pkg::*;
#(
  parameter int unsigned HDR_LEN      = DefHdrLen,
  parameter int unsigned SLOT_LEN     = DefSlotLen,
  parameter int unsigned PILOT_LEN    = DefPilotLen,
  parameter int unsigned PILOT_PERIOD = DefPilotPeriod,
  parameter int unsigned DUMMY_SLOTS  = DefDummySlots
) (
  input  logic                sys_clk,
  input  logic                rst_n,
  input  logic                adv,
  input  pl_state_e           state,
  input  logic [SlotCntW-1:0] slots,
  input  logic                pilots,
  output logic [SymCntW-1:0]  sym_cnt,
  output logic                seg_end,
  output logic                frame_end,
  output logic                pilot_due
);

  logic [SymCntW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [SlotCntW-1:0] slot_cnt_q, slot_cnt_d;
  logic [BlkCntW-1:0]  blk_cnt_q, blk_cnt_d;
  logic [SymCntW-1:0]  seg_last;
  logic                slot_last;
  logic                in_slot;

  always_comb begin
    case (state)
      StData, StDummy: seg_last = SymCntW'(SLOT_LEN - 1);
      StPilot:         seg_last = SymCntW'(PILOT_LEN - 1);
      default:         seg_last = SymCntW'(HDR_LEN - 1);
    endcase
    in_slot   = (state == StData) || (state == StDummy);
    slot_last = (state == StDummy) ? (slot_cnt_q == SlotCntW'(DUMMY_SLOTS - 1))
                                   : (slot_cnt_q == slots - SlotCntW'(1));
    seg_end   = (sym_cnt_q == seg_last);
    frame_end = seg_end && in_slot && slot_last;
    // A pilot follows every PILOT_PERIOD-th slot unless that slot is the frame's last.
    pilot_due = seg_end && pilots && (state == StData) &&
                (({1'b0, blk_cnt_q} + (BlkCntW+1)'(1)) == (BlkCntW+1)'(PILOT_PERIOD)) &&
                ((slot_cnt_q + SlotCntW'(1)) < slots);
  end

  always_comb begin
    sym_cnt_d  = sym_cnt_q;
    slot_cnt_d = slot_cnt_q;
    blk_cnt_d  = blk_cnt_q;
    if (adv) begin
      if (state == StIdle) begin
        // Leaving idle already consumes header symbol 0.
        sym_cnt_d  = SymCntW'(1);
        slot_cnt_d = '0;
        blk_cnt_d  = '0;
      end else if (seg_end) begin
        sym_cnt_d = '0;
        if (frame_end) begin
          slot_cnt_d = '0;
          blk_cnt_d  = '0;
        end else if (in_slot) begin
          slot_cnt_d = slot_cnt_q + SlotCntW'(1);
          blk_cnt_d  = blk_cnt_q + BlkCntW'(1);
        end else if (state == StPilot) begin
          blk_cnt_d = '0;
        end
      end else begin
        sym_cnt_d = sym_cnt_q + SymCntW'(1);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      sym_cnt_q  <= '0;
      slot_cnt_q <= '0;
      blk_cnt_q  <= '0;
    end else begin
      sym_cnt_q  <= sym_cnt_d;
      slot_cnt_q <= slot_cnt_d;
      blk_cnt_q  <= blk_cnt_d;
    end
  end

  assign sym_cnt = sym_cnt_q;

endmodule

// File: rtl/dvbs2_pl_sequencer.sv
// DVB-S2 PLFRAME sequencer: header, data slots, pilot blocks and dummy frames built
// from counters. underrun/cfg_err are same-cycle pulses qualified by fs_en.
module dvbs2_pl_sequencer
  import dvbs2_pl_pkg::*;
#(
  parameter int unsigned             DW           = DefDw,
  parameter int unsigned             HDR_LEN      = DefHdrLen,
  parameter int unsigned             SLOT_LEN     = DefSlotLen,
  parameter int unsigned             PILOT_LEN    = DefPilotLen,
  parameter int unsigned             PILOT_PERIOD = DefPilotPeriod,
  parameter int unsigned             MAX_SLOTS    = DefMaxSlots,
  parameter int unsigned             DUMMY_SLOTS  = DefDummySlots,
  parameter logic signed [DW-1:0]    DUMMY_VAL    = DW'(DefDummyVal)
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 fs_en,
  input  logic [8:0]           cfg_slots,
  input  logic                 cfg_pilots,
  input  logic                 xfec_frame_avail,
  input  logic                 xfec_vld,
  output logic                 xfec_rdy,
  input  logic signed [DW-1:0] xfec_re_in,
  input  logic signed [DW-1:0] xfec_im_in,
  output logic                 hdr_rd,
  output logic                 hdr_dummy,
  input  logic signed [DW-1:0] pl_header_re_in,
  input  logic signed [DW-1:0] pl_header_im_in,
  output logic                 pilot_rd,
  input  logic signed [DW-1:0] pl_pilot_re_in,
  input  logic signed [DW-1:0] pl_pilot_im_in,
  output logic                 oe,
  output logic                 sof,
  output logic signed [DW-1:0] symbol_re_out,
  output logic signed [DW-1:0] symbol_im_out,
  output logic                 underrun,
  output logic                 cfg_err
);

  pl_state_e           state_q, state_d;
  logic                dummy_q, dummy_d;
  logic                pilots_q, pilots_d;
  logic [8:0]          slots_q, slots_d;
  logic                adv, cfg_ok, start, start_dummy;
  logic [SymCntW-1:0]  sym_cnt;
  logic                seg_end, frame_end, pilot_due;
  logic                oe_q, sof_q, sof_d;
  logic signed [DW-1:0] sym_re_q, sym_im_q, sym_re_d, sym_im_d;

  pl_seg_counter #(
    .HDR_LEN      (HDR_LEN),
    .SLOT_LEN     (SLOT_LEN),
    .PILOT_LEN    (PILOT_LEN),
    .PILOT_PERIOD (PILOT_PERIOD),
    .DUMMY_SLOTS  (DUMMY_SLOTS)
  ) u_seg_counter (
    .sys_clk   (sys_clk),
    .rst_n     (rst_n),
    .adv       (adv),
    .state     (state_q),
    .slots     (slots_q),
    .pilots    (pilots_q),
    .sym_cnt   (sym_cnt),
    .seg_end   (seg_end),
    .frame_end (frame_end),
    .pilot_due (pilot_due)
  );

  // Requests are qualified by reset so nothing is pulled while the block is held.
  assign adv = fs_en & rst_n;

  always_comb begin
    cfg_ok      = (cfg_slots != 9'd0) && (cfg_slots <= 9'(MAX_SLOTS));
    start       = adv && ((state_q == StIdle) || frame_end);
    start_dummy = !(xfec_frame_avail && cfg_ok);

    hdr_rd    = adv && ((state_q == StIdle) || (state_q == StHdr));
    xfec_rdy  = adv && (state_q == StData);
    pilot_rd  = adv && (state_q == StPilot);
    hdr_dummy = rst_n && (((state_q == StHdr) && dummy_q) ||
                          ((state_q == StIdle) && fs_en && start_dummy));
    underrun  = xfec_rdy && !xfec_vld;
    cfg_err   = start && xfec_frame_avail && !cfg_ok;
  end

  always_comb begin
    state_d  = state_q;
    dummy_d  = dummy_q;
    slots_d  = slots_q;
    pilots_d = pilots_q;
    if (start) begin
      state_d = StHdr;
      dummy_d = start_dummy;
      if (!start_dummy) begin
        slots_d  = cfg_slots;
        pilots_d = cfg_pilots;
      end
    end else if (adv && seg_end) begin
      case (state_q)
        StHdr:   state_d = dummy_q ? StDummy : StData;
        StData:  state_d = pilot_due ? StPilot : StData;
        StPilot: state_d = StData;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sym_re_d = DUMMY_VAL;
    sym_im_d = DUMMY_VAL;
    case (state_q)
      StIdle, StHdr: begin
        sym_re_d = pl_header_re_in;
        sym_im_d = pl_header_im_in;
      end
      StData: begin
        if (xfec_vld) begin
          sym_re_d = xfec_re_in;
          sym_im_d = xfec_im_in;
        end
      end
      StPilot: begin
        sym_re_d = pl_pilot_re_in;
        sym_im_d = pl_pilot_im_in;
      end
      default: ;
    endcase
    sof_d = (state_q == StIdle) || ((state_q == StHdr) && (sym_cnt == '0));
  end

  always_ff @(posedge sys_clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      dummy_q  <= 1'b0;
      slots_q  <= '0;
      pilots_q <= 1'b0;
      oe_q     <= 1'b0;
      sof_q    <= 1'b0;
      sym_re_q <= '0;
      sym_im_q <= '0;
    end else if (fs_en) begin
      state_q  <= state_d;
      dummy_q  <= dummy_d;
      slots_q  <= slots_d;
      pilots_q <= pilots_d;
      oe_q     <= 1'b1;
      sof_q    <= sof_d;
      sym_re_q <= sym_re_d;
      sym_im_q <= sym_im_d;
    end
  end

  assign oe            = oe_q;
  assign sof           = sof_q;
  assign symbol_re_out = sym_re_q;
  assign symbol_im_out = sym_im_q;

endmodule

// File: doc/dvbs2_pl_sequencer.md
# dvbs2_pl_sequencer

- Parametrised DVB-S2 physical-layer framer for the kc705 DVB-S2 transmit chain, between the XFEC mapper, the PL-header generator and pilot generator, and the PL scrambler.
- Builds each PLFRAME itself from counters: 90-symbol header, S data slots of 90 symbols, optional 36-symbol pilot blocks every 16 slots.
- Inserts a dummy PLFRAME when no FEC frame is ready.
- Flags FEC underrun.

## Interface
Parameters:
- DW, 16: symbol component width (signed).
- HDR_LEN, 90: header symbols.
- SLOT_LEN, 90: symbols per slot.
- PILOT_LEN, 36: pilot block symbols.
- PILOT_PERIOD, 16: slots between pilot blocks.
- MAX_SLOTS, 360: largest legal S.
- DUMMY_SLOTS, 36: slots in a dummy frame.
- DUMMY_VAL, 16'sh0b50: re and im of dummy/underrun symbols.

Ports:
- sys_clk, in, 1: clock.
- rst_n, in, 1: reset, synchronous, active-low.
- fs_en, in, 1: symbol-rate enable. The block advances only on cycles with fs_en=1.
- cfg_slots, in, 9: S for the next frame. Sampled at frame start.
- cfg_pilots, in, 1: pilots on for the next frame. Sampled at frame start.
- xfec_frame_avail, in, 1: a complete FEC frame is buffered upstream.
- xfec_vld, in, 1: data symbol valid.
- xfec_rdy, out, 1: pops one data symbol per cycle with xfec_rdy & xfec_vld & fs_en.
- xfec_re_in, xfec_im_in, in, DW: data symbol.
- hdr_rd, out, 1: header symbol request. Data is valid in the same cycle.
- hdr_dummy, out, 1: the header generator must emit the dummy PLS code.
- pl_header_re_in, pl_header_im_in, in, DW: header symbol.
- pilot_rd, out, 1: pilot symbol request, same-cycle data.
- pl_pilot_re_in, pl_pilot_im_in, in, DW: pilot symbol.
- oe, out, 1: output symbol valid.
- sof, out, 1: first header symbol of a frame.
- symbol_re_out, symbol_im_out, out, DW: output symbol.
- underrun, out, 1: pulse per missing data symbol.
- cfg_err, out, 1: pulse when illegal cfg_slots is sampled.

## Operation
- FSM states: IDLE, HDR, DATA, PILOT, DUMMY.
- Counters: sym_cnt (7b, within segment), slot_cnt (9b), blk_cnt (4b, slots since last pilot).
- Frame-start decision, taken in IDLE or on the last symbol of a frame:
  - xfec_frame_avail=1 and 1≤cfg_slots≤MAX_SLOTS: latch S and pilots, go to HDR with data flag.
  - xfec_frame_avail=1 and cfg_slots illegal: cfg_err pulse, go to HDR as a dummy frame.
  - xfec_frame_avail=0: go to HDR as a dummy frame.
  - The FSM never returns to IDLE except after reset. Frames are back-to-back.
- HDR: hdr_rd=1 for HDR_LEN symbols. hdr_dummy is held for the whole dummy header. Output is the header input. Next state is DATA, or DUMMY for a dummy frame.
- DATA: xfec_rdy=1. Output is the xfec input.
  - If xfec_vld=0, output DUMMY_VAL/DUMMY_VAL with oe=1, pulse underrun, and count the symbol anyway.
  - After each slot: if pilots on, blk_cnt hits PILOT_PERIOD and slot_cnt<S, go to PILOT. Otherwise continue.
  - After slot S the frame ends.
- PILOT: pilot_rd=1 for PILOT_LEN symbols, then back to DATA with blk_cnt=0.
- DUMMY: DUMMY_SLOTS×SLOT_LEN symbols of DUMMY_VAL. No pilots.
- Pilot block count per frame is floor((S−1)/PILOT_PERIOD).
- Frame length is HDR_LEN + S·SLOT_LEN + pilot blocks·PILOT_LEN.
- cfg_* changes mid-frame have no effect.

## Timing
- Reset values: oe=0, sof=0, symbol_re_out=symbol_im_out=0, xfec_rdy=hdr_rd=pilot_rd=hdr_dummy=underrun=cfg_err=0. State=IDLE, all counters 0.
- rst_n low mid-frame: the frame is abandoned. The next frame starts with a header, never with resumed data.
- Request strobes (xfec_rdy, hdr_rd, pilot_rd) are combinational from state and are gated with fs_en.
- Outputs are registered: 1 cycle latency from the fs_en cycle that selected the symbol.
- With fs_en=0:
  - state, counters and all outputs hold, oe included;
  - no requests are issued;
  - underrun and cfg_err are 0.
- sof and oe rise together on the first header symbol.
- Frame boundaries are seamless: the last symbol of frame N is followed on the next fs_en by the header of frame N+1.
- The frame-start decision for IDLE exit is made in the same fs_en cycle as the first hdr_rd.

## Structure
- dvbs2_pl_pkg holds: the state enum, default length constants, and the DUMMY_VAL default.
- One sub-module, pl_seg_counter: sym_cnt/slot_cnt/blk_cnt with segment-end and frame-end flags.
- The FSM and output mux stay in the top module.

## Test plan
- Dummy frame: xfec_frame_avail=0 from reset.
  - 3330 oe symbols per frame; first 90 have hdr_dummy=1.
  - Remaining 3240 are 0x0b50/0x0b50.
  - sof repeats every 3330.
- Full frame, pilots on: S=360, pilots=1, fs_en=1.
  - 33282 symbols; 22 pilot blocks.
  - First pilot begins at symbol 90+1440=1530.
  - xfec pops exactly 32400.
- Short frame: S=90, pilots=1, fs_en toggling 1-of-3.
  - 8370 symbols; 5 pilot blocks.
  - Outputs hold during fs_en=0.
- Underrun: S=90, pilots=0, xfec_vld low for 3 symbols mid-slot.
  - 3 underrun pulses; those symbols are DUMMY_VAL.
  - Frame still 8190 long.
- Config errors and mid-frame changes:
  - cfg_slots=0 sampled: cfg_err pulse, dummy frame.
  - cfg_slots changed mid-frame: current frame length unchanged.
- Reset mid-DATA at slot 10:
  - All outputs 0 next cycle.
  - After release, first oe symbol has sof=1 and comes from the header input.
